// File: rtl/booth_pkg.sv
// Shared types and default sizing for the Booth multiplier operand-issue stage.
package booth_pkg;

  localparam int unsigned DefaultWidthIn  = 16;
  localparam int unsigned DefaultDepth    = 4;
  localparam int unsigned DefaultWidthTag = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

  // Packing order {a, b, tag} matches the flat FIFO word used by the top.
  typedef struct packed {
    logic [DefaultWidthIn-1:0]  a;
    logic [DefaultWidthIn-1:0]  b;
    logic [DefaultWidthTag-1:0] tag;
  } entry_t;

endpackage

// File: rtl/operand_fifo.sv
// Synchronous FIFO with flush; full/empty are derived from the level counter.
module operand_fifo
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * DefaultWidthIn + DefaultWidthTag,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [LvlW-1:0]  level_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      level_q <= level_q + LvlW'(push) - LvlW'(pop);
    end
  end

  assign rdata = mem_q[rptr_q];
  assign level = level_q;

endmodule

// File: rtl/booth_issue_queue.sv
// Buffers signed operand pairs and issues them one at a time to the sequential
// Booth multiplier, tagging each pair with a wrapping sequence number.
module booth_issue_queue
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH_IN  = DefaultWidthIn,
  parameter int unsigned DEPTH     = DefaultDepth,
  parameter int unsigned WIDTH_TAG = DefaultWidthTag
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH_IN-1:0]    in_a,
  input  logic [WIDTH_IN-1:0]    in_b,
  input  logic                   flush,
  output logic                   mul_start,
  output logic [WIDTH_IN-1:0]    mul_a,
  output logic [WIDTH_IN-1:0]    mul_b,
  output logic [WIDTH_TAG-1:0]   mul_tag,
  input  logic                   mul_done,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   spurious_done
);

  localparam int unsigned EntryW = 2 * WIDTH_IN + WIDTH_TAG;
  localparam int unsigned LvlW   = $clog2(DEPTH) + 1;

  state_e               state_q, state_d;
  logic                 push, pop;
  logic [EntryW-1:0]    wdata, rdata;
  logic [WIDTH_IN-1:0]  a_q, b_q;
  logic [WIDTH_TAG-1:0] tag_q, tag_ctr_q;
  logic                 spurious_q;

  // Ready looks only at registered occupancy, never at a same-cycle pop.
  assign in_ready = reset & ~flush & (level < LvlW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = (state_q == StIdle) & (level != '0);
  assign wdata    = {in_a, in_b, tag_ctr_q};

  operand_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata),
    .rdata (rdata),
    .level (level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pop) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (mul_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mul_start = (state_q == StIssue);
    busy      = (state_q != StIdle) | (level != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q        <= '0;
      b_q        <= '0;
      tag_q      <= '0;
      tag_ctr_q  <= '0;
      spurious_q <= 1'b0;
    end else begin
      if (pop) begin
        {a_q, b_q, tag_q} <= rdata;
      end
      if (push) begin
        tag_ctr_q <= tag_ctr_q + WIDTH_TAG'(1);
      end
      // Completion outside WAIT is ignored by the FSM but latched for diagnosis.
      if (mul_done && (state_q != StWait)) begin
        spurious_q <= 1'b1;
      end
    end
  end

  assign mul_a         = a_q;
  assign mul_b         = b_q;
  assign mul_tag       = tag_q;
  assign spurious_done = spurious_q;

endmodule

// File: tb/tb_booth_issue_queue.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_booth_issue_queue;
  import booth_pkg::*;

  localparam int W = 16;
  localparam int D = 4;
  localparam int T = 4;
  localparam int MIdle = 0, MIssue = 1, MWait = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic         man_done = 1'b0;
  logic         auto_en = 1'b0;
  logic         auto_done = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         mul_done;
  logic         in_ready, mul_start, busy, spurious_done;
  logic [W-1:0] mul_a, mul_b;
  logic [T-1:0] mul_tag;
  logic [2:0]   level;

  assign mul_done = auto_en ? auto_done : man_done;

  booth_issue_queue dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .flush         (flush),
    .mul_start     (mul_start),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_tag       (mul_tag),
    .mul_done      (mul_done),
    .level         (level),
    .busy          (busy),
    .spurious_done (spurious_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending pairs as a queue, issue phase as a small integer.
  entry_t       q[$];
  int           m_st = MIdle;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic [T-1:0] m_tag = '0, m_ctr = '0;
  logic         m_spur = 1'b0;

  initial forever begin
    int     lvl;
    bit     rdy, pu, po;
    entry_t h;
    @(posedge clk or negedge reset);
    if (!reset) begin
      q.delete();
      m_st = MIdle; m_a = '0; m_b = '0; m_tag = '0; m_ctr = '0; m_spur = 1'b0;
    end else begin
      lvl = q.size();
      rdy = !flush && (lvl < D);
      pu  = in_valid && rdy;
      po  = (m_st == MIdle) && (lvl != 0);
      if (mul_done && m_st != MWait) m_spur = 1'b1;
      if (po) begin
        h = q.pop_front();
        m_a = h.a; m_b = h.b; m_tag = h.tag;
      end
      case (m_st)
        MIdle:   if (po) m_st = MIssue;
        MIssue:  m_st = MWait;
        default: if (mul_done) m_st = MIdle;
      endcase
      if (flush) q.delete();
      if (pu) begin
        h.a = in_a; h.b = in_b; h.tag = m_ctr;
        q.push_back(h);
        m_ctr = m_ctr + 1'b1;
      end
    end
  end

  // Compare process, sampled on the falling edge.
  logic prev_start = 1'b0;
  initial forever begin
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(reset && !flush && q.size() < D));
    chk("level", 32'(level), 32'(q.size()));
    chk("busy", 32'(busy), 32'(m_st != MIdle || q.size() != 0));
    chk("mul_start", 32'(mul_start), 32'(m_st == MIssue));
    chk("mul_a", 32'(mul_a), 32'(m_a));
    chk("mul_b", 32'(mul_b), 32'(m_b));
    chk("mul_tag", 32'(mul_tag), 32'(m_tag));
    chk("spurious_done", 32'(spurious_done), 32'(m_spur));
    chk("start_spacing", 32'(prev_start & mul_start), 32'(0));
    prev_start = mul_start;
  end

  // Multiplier stand-in: random latency after each start.
  int cnt = 0;
  initial forever begin
    @(negedge clk);
    #1;
    if (m_st == MIssue) begin
      cnt = $urandom_range(0, 5);
      auto_done = 1'b0;
    end else if (m_st == MWait) begin
      if (cnt == 0) auto_done = 1'b1;
      else begin
        cnt--;
        auto_done = 1'b0;
      end
    end else begin
      auto_done = 1'b0;
    end
  end

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic drain();
    auto_en = 1'b1;
    for (int i = 0; i < 400 && !(m_st == MIdle && q.size() == 0); i++) cyc();
    chk("drain_busy", 32'(busy), 32'(0));
    auto_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
    chk("rst_ready", 32'(in_ready), 32'(1));
    chk("rst_level", 32'(level), 32'(0));

    // Single pair.
    in_valid = 1'b1; in_a = 16'h0007; in_b = 16'hFFFD;
    cyc();
    in_valid = 1'b0;
    chk("single_level", 32'(level), 32'(1));
    chk("single_nostart", 32'(mul_start), 32'(0));
    cyc();
    chk("single_start", 32'(mul_start), 32'(1));
    chk("single_a", 32'(mul_a), 32'h0007);
    chk("single_b", 32'(mul_b), 32'hFFFD);
    chk("single_tag", 32'(mul_tag), 32'(0));
    cyc();
    chk("single_start_low", 32'(mul_start), 32'(0));
    chk("single_hold_a", 32'(mul_a), 32'h0007);
    man_done = 1'b1;
    cyc();
    man_done = 1'b0;
    chk("single_idle", 32'(busy), 32'(0));

    // Fill to DEPTH with completion held off.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
      cyc();
    end
    chk("fill_level", 32'(level), 32'(4));
    chk("fill_ready", 32'(in_ready), 32'(0));
    man_done = 1'b1;
    cyc();
    man_done = 1'b0;
    repeat (2) cyc();
    in_valid = 1'b0;
    drain();

    // Spurious completion while idle.
    man_done = 1'b1;
    cyc();
    man_done = 1'b0;
    chk("spur_set", 32'(spurious_done), 32'(1));
    chk("spur_idle", 32'(busy), 32'(0));
    repeat (3) cyc();
    chk("spur_sticky", 32'(spurious_done), 32'(1));

    // Flush during WAIT with three queued.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
      cyc();
    end
    chk("flush_pre_level", 32'(level), 32'(3));
    flush = 1'b1;
    #1;
    chk("flush_ready", 32'(in_ready), 32'(0));
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_level", 32'(level), 32'(0));
    chk("flush_inflight", 32'(busy), 32'(1));
    man_done = 1'b1;
    cyc();
    man_done = 1'b0;
    repeat (4) cyc();
    chk("flush_done", 32'(busy), 32'(0));

    // Reset mid-WAIT with two queued.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    chk("rstw_level_pre", 32'(level), 32'(2));
    #1;
    reset = 1'b0;
    #1;
    chk("rstw_ready", 32'(in_ready), 32'(0));
    chk("rstw_level", 32'(level), 32'(0));
    chk("rstw_busy", 32'(busy), 32'(0));
    chk("rstw_start", 32'(mul_start), 32'(0));
    chk("rstw_a", 32'(mul_a), 32'(0));
    chk("rstw_tag", 32'(mul_tag), 32'(0));
    chk("rstw_spur", 32'(spurious_done), 32'(0));
    cyc();
    reset = 1'b1;
    #1;
    chk("rstw_ready_rel", 32'(in_ready), 32'(1));
    chk("rstw_level_rel", 32'(level), 32'(0));

    // Randomized traffic; tags wrap many times.
    auto_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      in_valid = ($urandom_range(0, 3) != 0);
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      flush    = (m_st != MIdle) && ($urandom_range(0, 40) == 0);
    end
    cyc();
    in_valid = 1'b0;
    flush    = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
